// File: rtl/lcd_timing_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_timing_pkg
// Purpose  : Default panel timing, FSM encoding and line/frame total helpers
//            shared by the LCD timing generator files.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_timing_pkg;

    // iPhone-7 class panel defaults
    localparam int DEF_H_ACTIVE = 750;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 8;
    localparam int DEF_H_BP     = 16;
    localparam int DEF_V_ACTIVE = 1334;
    localparam int DEF_V_FP     = 8;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 8;

    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam bit DEF_DE_POL   = 1'b1;

    localparam int DEF_REQ_LEAD = 1;
    localparam int DEF_COORD_W  = 11;
    localparam int DEF_DATA_W   = 24;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Raw timing bundle carried through the source-latency delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } sync_bundle_t;

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage : lcd_timing_pkg
`default_nettype wire

// File: rtl/lcd_timing_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_timing_gen_if
// Purpose  : Pixel-source request/return and panel-pin bundle of the LCD
//            timing generator. master = generator, slave = source/panel side.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_timing_gen_if
    import lcd_timing_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int DATA_W  = DEF_DATA_W
) ();

    logic               pixel_request;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] max_y;
    logic [DATA_W-1:0]  pixel_data;

    logic               hs;
    logic               vs;
    logic               den;
    logic [DATA_W-1:0]  rgb;
    logic               frame_start;

    modport master (
        output pixel_request,
        output pixel_x,
        output pixel_y,
        output max_x,
        output max_y,
        input  pixel_data,
        output hs,
        output vs,
        output den,
        output rgb,
        output frame_start
    );

    modport slave (
        input  pixel_request,
        input  pixel_x,
        input  pixel_y,
        input  max_x,
        input  max_y,
        output pixel_data,
        input  hs,
        input  vs,
        input  den,
        input  rgb,
        input  frame_start
    );

endinterface : lcd_timing_gen_if
`default_nettype wire

// File: rtl/lcd_timing_gen_sig_delay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sig_delay
// Purpose  : Parametrised-depth shift register with per-bit reset value;
//            depth 0 degenerates to a plain wire.
// Revision : 1.0 - initial release
// ============================================================================
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // clock and reset have no load at zero depth
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule : sig_delay
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_timing_gen
// Purpose  : RGB-panel timing generator: pixel requests ahead of the pins,
//            registered HS/VS/DEN/RGB, frame-boundary start/stop.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter bit DE_POL   = DEF_DE_POL,
    parameter int REQ_LEAD = DEF_REQ_LEAD,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             enable,
    output logic             running,
    lcd_timing_gen_if.master bus
);

    localparam int C_H_T = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int C_V_T = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] C_H_LAST     = COORD_W'(C_H_T - 1);
    localparam logic [COORD_W-1:0] C_V_LAST     = COORD_W'(C_V_T - 1);
    localparam logic [COORD_W-1:0] C_H_ACT      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] C_V_ACT      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] C_H_SYNC_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] C_H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] C_V_SYNC_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] C_V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] C_MAX_X      = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] C_MAX_Y      = COORD_W'(V_ACTIVE - 1);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] hcnt_q, hcnt_d;
    logic [COORD_W-1:0] vcnt_q, vcnt_d;

    logic               w_run;
    logic               w_h_last;
    logic               w_v_last;
    sync_bundle_t       w_raw;
    sync_bundle_t       w_dly;

    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               den_q, den_d;
    logic               fs_q, fs_d;
    logic [DATA_W-1:0]  rgb_q, rgb_d;

    assign w_run    = (state_q == ST_RUN);
    assign w_h_last = (hcnt_q == C_H_LAST);
    assign w_v_last = (vcnt_q == C_V_LAST);

    // ------------------------------------------------------------------------
    // Frame FSM and raster counters
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        case (state_q)
            ST_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_h_last) begin
                    hcnt_d = '0;
                    if (w_v_last) begin
                        vcnt_d = '0;
                        // enable is only sampled on the last cycle of a frame
                        if (!enable) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hcnt_d  = '0;
                vcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Raw timing decode and pixel request
    // ------------------------------------------------------------------------
    always_comb begin
        w_raw    = '0;
        w_raw.de = w_run && (hcnt_q < C_H_ACT) && (vcnt_q < C_V_ACT);
        w_raw.hs = w_run && (hcnt_q >= C_H_SYNC_BEG) && (hcnt_q < C_H_SYNC_END);
        w_raw.vs = w_run && (vcnt_q >= C_V_SYNC_BEG) && (vcnt_q < C_V_SYNC_END);
        w_raw.fs = w_run && (hcnt_q == '0) && (vcnt_q == '0);
    end

    assign bus.pixel_request = w_raw.de;
    assign bus.pixel_x       = w_raw.de ? hcnt_q : '0;
    assign bus.pixel_y       = w_raw.de ? vcnt_q : '0;
    assign bus.max_x         = C_MAX_X;
    assign bus.max_y         = C_MAX_Y;
    assign running           = w_run;

    // Match the source read latency so syncs meet their pixel at the pins
    sig_delay #(
        .WIDTH   ($bits(sync_bundle_t)),
        .DEPTH   (REQ_LEAD),
        .RST_VAL ('0)
    ) u_sync_dly (
        .clk   (pclk),
        .rst_n (rst_n),
        .d     (w_raw),
        .q     (w_dly)
    );

    // ------------------------------------------------------------------------
    // Output register with polarity applied
    // ------------------------------------------------------------------------
    always_comb begin
        hs_d  = w_dly.hs ? HS_POL : ~HS_POL;
        vs_d  = w_dly.vs ? VS_POL : ~VS_POL;
        den_d = w_dly.de ? DE_POL : ~DE_POL;
        fs_d  = w_dly.fs;
        rgb_d = w_dly.de ? bus.pixel_data : '0;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            den_q <= ~DE_POL;
            fs_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            den_q <= den_d;
            fs_q  <= fs_d;
            rgb_q <= rgb_d;
        end
    end

    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.den         = den_q;
    assign bus.rgb         = rgb_q;
    assign bus.frame_start = fs_q;

endmodule : lcd_timing_gen
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timing_gen
// Purpose  : Self-checking bench for lcd_timing_gen on a tiny 8x6 raster,
//            REQ_LEAD = 2 main instance plus 0 and 7 alignment instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_gen;
    import lcd_timing_pkg::*;

    localparam int CW  = 8;
    localparam int DW  = 24;
    localparam int HT  = 8;
    localparam int VT  = 6;
    localparam int FT  = HT * VT;
    localparam int BIG = 1000000;

    logic pclk   = 1'b0;
    logic rst_n  = 1'b1;
    logic enable = 1'b0;
    logic en_sw  = 1'b0;
    logic running2, running0, running7;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    lcd_timing_gen_if #(.COORD_W(CW), .DATA_W(DW)) bus2 ();
    lcd_timing_gen_if #(.COORD_W(CW), .DATA_W(DW)) bus0 ();
    lcd_timing_gen_if #(.COORD_W(CW), .DATA_W(DW)) bus7 ();

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1),
        .REQ_LEAD(2), .COORD_W(CW), .DATA_W(DW)
    ) u_dut2 (.pclk(pclk), .rst_n(rst_n), .enable(enable), .running(running2), .bus(bus2));

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1),
        .REQ_LEAD(0), .COORD_W(CW), .DATA_W(DW)
    ) u_dut0 (.pclk(pclk), .rst_n(rst_n), .enable(en_sw), .running(running0), .bus(bus0));

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1),
        .REQ_LEAD(7), .COORD_W(CW), .DATA_W(DW)
    ) u_dut7 (.pclk(pclk), .rst_n(rst_n), .enable(en_sw), .running(running7), .bus(bus7));

    // Pixel sources: return {y,x} after their fixed read latency
    logic [DW-1:0] src2_q [2] = '{default: '0};
    logic [DW-1:0] src7_q [7] = '{default: '0};

    always @(posedge pclk) begin
        src2_q[0] <= {8'h00, bus2.pixel_y, bus2.pixel_x};
        src2_q[1] <= src2_q[0];
        src7_q[0] <= {8'h00, bus7.pixel_y, bus7.pixel_x};
        for (int i = 1; i < 7; i++) src7_q[i] <= src7_q[i-1];
    end

    assign bus2.pixel_data = src2_q[1];
    assign bus7.pixel_data = src7_q[6];
    assign bus0.pixel_data = {8'h00, bus0.pixel_y, bus0.pixel_x};

    // Reference raster: p = counted cycle index since the frame start, lim = cycles counted
    function automatic bit m_de(input int p, input int lim);
        return (p >= 0) && (p < lim) && ((p % HT) < 4) && (((p / HT) % VT) < 3);
    endfunction

    function automatic bit m_hs(input int p, input int lim);
        return (p >= 0) && (p < lim) && ((p % HT) >= 5) && ((p % HT) <= 6);
    endfunction

    function automatic bit m_vs(input int p, input int lim);
        return (p >= 0) && (p < lim) && (((p / HT) % VT) == 4);
    endfunction

    function automatic bit m_fs(input int p, input int lim);
        return (p >= 0) && (p < lim) && ((p % FT) == 0);
    endfunction

    // {hs, vs, den, frame_start} at the pins; hs/vs active-low, den active-high
    function automatic logic [3:0] m_pins(input int p, input int lim);
        return {~m_hs(p, lim), ~m_vs(p, lim), m_de(p, lim), m_fs(p, lim)};
    endfunction

    function automatic logic [DW-1:0] m_pix(input int p);
        logic [CW-1:0] x, y;
        x = CW'(p % HT);
        y = CW'((p / HT) % VT);
        return {8'h00, y, x};
    endfunction

    function automatic logic [2*CW:0] m_req(input int p, input int lim);
        if (m_de(p, lim)) return {1'b1, CW'((p / HT) % VT), CW'(p % HT)};
        return '0;
    endfunction

    task automatic do_reset();
        @(negedge pclk);
        rst_n  = 1'b0;
        enable = 1'b0;
        en_sw  = 1'b0;
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        enable = 1'b0;
        en_sw  = 1'b0;
        repeat (2) @(negedge pclk);
        n_cmp++;
        if ({bus2.hs, bus2.vs, bus2.den, bus2.frame_start} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_pins: got %b want %b", {bus2.hs, bus2.vs, bus2.den, bus2.frame_start}, 4'b1100);
        end
        n_cmp++;
        if ({bus2.rgb, bus2.pixel_request, running2, running0, running7} !== '0) begin
            n_err++;
            $display("FAIL reset_rgb_req_run: got rgb=%h req=%b run=%b%b%b want all 0",
                     bus2.rgb, bus2.pixel_request, running2, running0, running7);
        end
        n_cmp++;
        if ({bus2.max_x, bus2.max_y} !== {8'd3, 8'd2}) begin
            n_err++;
            $display("FAIL max_xy: got %0d,%0d want 3,2", bus2.max_x, bus2.max_y);
        end
        rst_n = 1'b1;
        // enable low: stays idle
        for (int c = 0; c < 10; c++) begin
            @(negedge pclk);
            n_cmp++;
            if ({bus2.pixel_request, running2, bus2.den, bus2.hs} !== 4'b0001) begin
                n_err++;
                $display("FAIL idle_hold c=%0d: got req/run/den/hs=%b want 0001", c,
                         {bus2.pixel_request, running2, bus2.den, bus2.hs});
            end
        end
    endtask

    task automatic test_frames();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_rgb;
        int n_fs = 0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 2 * FT + 3; c++) begin
            @(negedge pclk);
            if (m_de(c, BIG)) q.push_back(m_pix(c));
            n_cmp++;
            if ({bus2.pixel_request, bus2.pixel_y, bus2.pixel_x} !== m_req(c, BIG)) begin
                n_err++;
                $display("FAIL frames_req c=%0d: got %h want %h", c,
                         {bus2.pixel_request, bus2.pixel_y, bus2.pixel_x}, m_req(c, BIG));
            end
            n_cmp++;
            if ({bus2.hs, bus2.vs, bus2.den, bus2.frame_start} !== m_pins(c - 3, BIG)) begin
                n_err++;
                $display("FAIL frames_pins c=%0d: got %b want %b", c,
                         {bus2.hs, bus2.vs, bus2.den, bus2.frame_start}, m_pins(c - 3, BIG));
            end
            exp_rgb = '0;
            if (m_de(c - 3, BIG)) exp_rgb = (q.size() > 0) ? q.pop_front() : 24'hBADBAD;
            n_cmp++;
            if (bus2.rgb !== exp_rgb) begin
                n_err++;
                $display("FAIL frames_rgb c=%0d: got %h want %h", c, bus2.rgb, exp_rgb);
            end
            n_cmp++;
            if (running2 !== 1'b1) begin
                n_err++;
                $display("FAIL frames_running c=%0d: got %b want 1", c, running2);
            end
            if (bus2.frame_start === 1'b1) n_fs++;
        end
        n_cmp++;
        if (n_fs != 2) begin
            n_err++;
            $display("FAIL frames_fs_count: got %0d want 2", n_fs);
        end
    endtask

    task automatic test_sync_shape();
        int n_hs = 0;
        int n_vs = 0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < FT + 3; c++) begin
            @(negedge pclk);
            n_cmp++;
            if ({bus2.hs, bus2.vs} !== m_pins(c - 3, BIG) >> 2) begin
                n_err++;
                $display("FAIL sync_shape c=%0d: got hs/vs=%b%b want %b", c, bus2.hs, bus2.vs,
                         m_pins(c - 3, BIG) >> 2);
            end
            if (c >= 3 && bus2.hs === 1'b0) n_hs++;
            if (c >= 3 && bus2.vs === 1'b0) n_vs++;
        end
        n_cmp++;
        if (n_hs != 2 * VT || n_vs != HT) begin
            n_err++;
            $display("FAIL sync_counts: got hs=%0d vs=%0d want %0d %0d", n_hs, n_vs, 2 * VT, HT);
        end
    endtask

    task automatic test_stop();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_rgb;
        int n_fs = 0;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < FT + 10; c++) begin
            @(negedge pclk);
            if (m_de(c, FT)) q.push_back(m_pix(c));
            n_cmp++;
            if ({running2, bus2.pixel_request, bus2.pixel_y, bus2.pixel_x} !== {(c < FT), m_req(c, FT)}) begin
                n_err++;
                $display("FAIL stop_run_req c=%0d: got %h want %h", c,
                         {running2, bus2.pixel_request, bus2.pixel_y, bus2.pixel_x}, {(c < FT), m_req(c, FT)});
            end
            n_cmp++;
            if ({bus2.hs, bus2.vs, bus2.den, bus2.frame_start} !== m_pins(c - 3, FT)) begin
                n_err++;
                $display("FAIL stop_pins c=%0d: got %b want %b", c,
                         {bus2.hs, bus2.vs, bus2.den, bus2.frame_start}, m_pins(c - 3, FT));
            end
            exp_rgb = '0;
            if (m_de(c - 3, FT)) exp_rgb = (q.size() > 0) ? q.pop_front() : 24'hBADBAD;
            n_cmp++;
            if (bus2.rgb !== exp_rgb) begin
                n_err++;
                $display("FAIL stop_rgb c=%0d: got %h want %h", c, bus2.rgb, exp_rgb);
            end
            if (bus2.frame_start === 1'b1) n_fs++;
            if (c == 10) enable = 1'b0;
        end
        n_cmp++;
        if (n_fs != 1) begin
            n_err++;
            $display("FAIL stop_fs_count: got %0d want 1", n_fs);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_rgb;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < FT + 24; c++) begin
            @(negedge pclk);
            if (m_de(c, BIG)) q.push_back(m_pix(c));
            n_cmp++;
            if ({running2, bus2.pixel_request, bus2.pixel_y, bus2.pixel_x} !== {1'b1, m_req(c, BIG)}) begin
                n_err++;
                $display("FAIL b2b_run_req c=%0d: got %h want %h", c,
                         {running2, bus2.pixel_request, bus2.pixel_y, bus2.pixel_x}, {1'b1, m_req(c, BIG)});
            end
            n_cmp++;
            if ({bus2.hs, bus2.vs, bus2.den, bus2.frame_start} !== m_pins(c - 3, BIG)) begin
                n_err++;
                $display("FAIL b2b_pins c=%0d: got %b want %b", c,
                         {bus2.hs, bus2.vs, bus2.den, bus2.frame_start}, m_pins(c - 3, BIG));
            end
            exp_rgb = '0;
            if (m_de(c - 3, BIG)) exp_rgb = (q.size() > 0) ? q.pop_front() : 24'hBADBAD;
            n_cmp++;
            if (bus2.rgb !== exp_rgb) begin
                n_err++;
                $display("FAIL b2b_rgb c=%0d: got %h want %h", c, bus2.rgb, exp_rgb);
            end
            if (c == 20) enable = 1'b0;
            if (c == FT - 1) enable = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_rgb;
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 12; c++) @(negedge pclk);
        n_cmp++;
        if ({bus2.den, bus2.rgb} !== {1'b1, m_pix(8)}) begin
            n_err++;
            $display("FAIL areset_pre: got den=%b rgb=%h want 1 %h", bus2.den, bus2.rgb, m_pix(8));
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus2.hs, bus2.vs, bus2.den, bus2.frame_start} !== 4'b1100) begin
            n_err++;
            $display("FAIL areset_pins: got %b want 1100", {bus2.hs, bus2.vs, bus2.den, bus2.frame_start});
        end
        n_cmp++;
        if ({bus2.rgb, running2, bus2.pixel_request, bus2.pixel_x, bus2.pixel_y} !== '0) begin
            n_err++;
            $display("FAIL areset_state: got rgb=%h run=%b req=%b x=%0d y=%0d want all 0",
                     bus2.rgb, running2, bus2.pixel_request, bus2.pixel_x, bus2.pixel_y);
        end
        @(negedge pclk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge pclk);
            if (m_de(c, BIG)) q.push_back(m_pix(c));
            n_cmp++;
            if ({running2, bus2.pixel_request, bus2.pixel_y, bus2.pixel_x} !== {1'b1, m_req(c, BIG)}) begin
                n_err++;
                $display("FAIL areset_restart c=%0d: got %h want %h", c,
                         {running2, bus2.pixel_request, bus2.pixel_y, bus2.pixel_x}, {1'b1, m_req(c, BIG)});
            end
            exp_rgb = '0;
            if (m_de(c - 3, BIG)) exp_rgb = (q.size() > 0) ? q.pop_front() : 24'hBADBAD;
            n_cmp++;
            if ({bus2.hs, bus2.vs, bus2.den, bus2.frame_start, bus2.rgb} !== {m_pins(c - 3, BIG), exp_rgb}) begin
                n_err++;
                $display("FAIL areset_pins_rgb c=%0d: got %b/%h want %b/%h", c,
                         {bus2.hs, bus2.vs, bus2.den, bus2.frame_start}, bus2.rgb, m_pins(c - 3, BIG), exp_rgb);
            end
        end
    endtask

    task automatic test_req_lead_sweep();
        logic [DW-1:0] q0[$];
        logic [DW-1:0] q7[$];
        logic [DW-1:0] exp0, exp7;
        do_reset();
        en_sw = 1'b1;
        for (int c = 0; c < 3 * FT + 8; c++) begin
            @(negedge pclk);
            if (m_de(c, BIG)) begin
                q0.push_back(m_pix(c));
                q7.push_back(m_pix(c));
            end
            n_cmp++;
            if ({bus0.pixel_request, bus0.pixel_y, bus0.pixel_x} !== m_req(c, BIG) ||
                {bus7.pixel_request, bus7.pixel_y, bus7.pixel_x} !== m_req(c, BIG)) begin
                n_err++;
                $display("FAIL sweep_req c=%0d: got %h/%h want %h", c,
                         {bus0.pixel_request, bus0.pixel_y, bus0.pixel_x},
                         {bus7.pixel_request, bus7.pixel_y, bus7.pixel_x}, m_req(c, BIG));
            end
            exp0 = '0;
            if (m_de(c - 1, BIG)) exp0 = (q0.size() > 0) ? q0.pop_front() : 24'hBADBAD;
            n_cmp++;
            if ({bus0.hs, bus0.vs, bus0.den, bus0.frame_start, bus0.rgb} !== {m_pins(c - 1, BIG), exp0}) begin
                n_err++;
                $display("FAIL sweep_lead0 c=%0d: got %b/%h want %b/%h", c,
                         {bus0.hs, bus0.vs, bus0.den, bus0.frame_start}, bus0.rgb, m_pins(c - 1, BIG), exp0);
            end
            exp7 = '0;
            if (m_de(c - 8, BIG)) exp7 = (q7.size() > 0) ? q7.pop_front() : 24'hBADBAD;
            n_cmp++;
            if ({bus7.hs, bus7.vs, bus7.den, bus7.frame_start, bus7.rgb} !== {m_pins(c - 8, BIG), exp7}) begin
                n_err++;
                $display("FAIL sweep_lead7 c=%0d: got %b/%h want %b/%h", c,
                         {bus7.hs, bus7.vs, bus7.den, bus7.frame_start}, bus7.rgb, m_pins(c - 8, BIG), exp7);
            end
        end
        en_sw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_sync_shape();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_req_lead_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_lcd_timing_gen
`default_nettype wire
